// File: rtl/mm_verify_tx_sched.sv
// MAC Merge verify sequencer and transmit-path arbiter.
// Runs the verify/respond handshake that gates preemptable traffic. It also
// hands the single MAC transmit path to one of four sources at a time.
module mm_verify_tx_sched #(
  parameter int VERIFY_TIME_CYC = 1000,
  parameter int VERIFY_LIMIT    = 3,
  parameter int TMR_W           = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       link_fail,
  input  logic       p_enable,
  input  logic       disable_verify,
  input  logic       express_req,
  input  logic       pmac_req,
  input  logic       tx_done,
  input  logic       rcv_v,
  input  logic       rcv_r,
  output logic       grant_e,
  output logic       grant_r,
  output logic       grant_v,
  output logic       grant_p,
  output logic [2:0] verify_state,
  output logic       verified,
  output logic       verify_fail,
  output logic [1:0] verify_cnt,
  output logic       preempt_en
);

  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_IDLE        = 3'd1,
    ST_SEND_VERIFY = 3'd2,
    ST_WAIT_RESP   = 3'd3,
    ST_VERIFIED    = 3'd4,
    ST_FAIL        = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OWN_NONE = 3'd0,
    OWN_E    = 3'd1,
    OWN_R    = 3'd2,
    OWN_V    = 3'd3,
    OWN_P    = 3'd4
  } owner_t;

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(VERIFY_TIME_CYC - 1);
  localparam logic [1:0]       LIMIT    = 2'(VERIFY_LIMIT);

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             resp_pend_q, resp_pend_d;

  logic abort;
  logic send_v_pend;
  logic timer_done;

  // Any of these conditions restarts verification from scratch.
  assign abort       = link_fail | disable_verify | ~p_enable;
  // A verify request is withdrawn as soon as an abort is seen so that no
  // stray verify mPacket is started while the FSM heads back to INIT.
  assign send_v_pend = (state_q == ST_SEND_VERIFY) & ~abort;
  assign timer_done  = (timer_q == '0);

  assign verified     = (state_q == ST_VERIFIED);
  assign verify_fail  = (state_q == ST_FAIL);
  assign verify_state = state_q;
  assign verify_cnt   = cnt_q;
  assign preempt_en   = p_enable & (verified | disable_verify) & ~link_fail;

  assign grant_e = (owner_q == OWN_E);
  assign grant_r = (owner_q == OWN_R);
  assign grant_v = (owner_q == OWN_V);
  assign grant_p = (owner_q == OWN_P);

  // State, owner, counters and respond flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      timer_q     <= '0;
      resp_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      resp_pend_q <= resp_pend_d;
    end
  end

  // Verify FSM: next state, attempt counter and response timer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    if (abort) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_INIT: state_d = ST_IDLE;
        ST_IDLE: state_d = ST_SEND_VERIFY;
        ST_SEND_VERIFY: begin
          if (tx_done && (owner_q == OWN_V)) begin
            state_d = ST_WAIT_RESP;
            timer_d = TMR_LOAD;
            cnt_d   = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
          end
        end
        ST_WAIT_RESP: begin
          if (rcv_r) begin
            state_d = ST_VERIFIED;
          end else if (timer_done) begin
            state_d = (cnt_q < LIMIT) ? ST_IDLE : ST_FAIL;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_VERIFIED: state_d = ST_VERIFIED;
        ST_FAIL:     state_d = ST_FAIL;
        default:     state_d = ST_INIT;
      endcase
    end
  end

  // Single-entry respond queue; a new rcv_v beats a simultaneous release.
  always_comb begin
    resp_pend_d = resp_pend_q;
    if (link_fail || !p_enable) begin
      resp_pend_d = 1'b0;
    end else if (rcv_v) begin
      resp_pend_d = 1'b1;
    end else if (tx_done && (owner_q == OWN_R)) begin
      resp_pend_d = 1'b0;
    end
  end

  // Fixed-priority arbiter; owner held until tx_done, then one idle cycle.
  always_comb begin
    owner_d = owner_q;
    if (link_fail) begin
      owner_d = OWN_NONE;
    end else if (owner_q != OWN_NONE) begin
      if (tx_done) owner_d = OWN_NONE;
    end else if (express_req) begin
      owner_d = OWN_E;
    end else if (resp_pend_q) begin
      owner_d = OWN_R;
    end else if (send_v_pend) begin
      owner_d = OWN_V;
    end else if (pmac_req && preempt_en) begin
      owner_d = OWN_P;
    end
  end

endmodule

// File: tb/tb_mm_verify_tx_sched.sv
// Bench for mm_verify_tx_sched: directed scenarios plus a randomized run,
// all checked every cycle against a behavioural model of the handshake.
module tb_mm_verify_tx_sched;

  localparam int VT = 8;
  localparam int VL = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic link_fail = 0, p_enable = 0, disable_verify = 0;
  logic express_req = 0, pmac_req = 0, tx_done = 0, rcv_v = 0, rcv_r = 0;
  logic grant_e, grant_r, grant_v, grant_p;
  logic [2:0] verify_state;
  logic verified, verify_fail, preempt_en;
  logic [1:0] verify_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int gp_seen = 0;

  always #5 clk = ~clk;

  mm_verify_tx_sched #(.VERIFY_TIME_CYC(VT), .VERIFY_LIMIT(VL), .TMR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .link_fail(link_fail), .p_enable(p_enable),
    .disable_verify(disable_verify), .express_req(express_req), .pmac_req(pmac_req),
    .tx_done(tx_done), .rcv_v(rcv_v), .rcv_r(rcv_r),
    .grant_e(grant_e), .grant_r(grant_r), .grant_v(grant_v), .grant_p(grant_p),
    .verify_state(verify_state), .verified(verified), .verify_fail(verify_fail),
    .verify_cnt(verify_cnt), .preempt_en(preempt_en)
  );

  // ---------------- behavioural model ----------------
  // state: 0 INIT 1 IDLE 2 SEND 3 WAIT 4 VERIFIED 5 FAIL
  // owner: 0 none 1 express 2 respond 3 verify 4 pmac
  int m_state = 0, m_owner = 0, m_cnt = 0, m_elapsed = 0;
  bit m_resp = 0;

  wire m_abort = link_fail || disable_verify || !p_enable;
  wire m_pe    = p_enable && ((m_state == 4) || disable_verify) && !link_fail;
  wire m_sendv = (m_state == 2) && !m_abort;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= 0; m_owner <= 0; m_cnt <= 0; m_elapsed <= 0; m_resp <= 0;
    end else begin
      if (link_fail) m_owner <= 0;
      else if (m_owner != 0) m_owner <= tx_done ? 0 : m_owner;
      else if (express_req) m_owner <= 1;
      else if (m_resp) m_owner <= 2;
      else if (m_sendv) m_owner <= 3;
      else if (pmac_req && m_pe) m_owner <= 4;

      if (link_fail || !p_enable) m_resp <= 0;
      else if (rcv_v) m_resp <= 1;
      else if (tx_done && m_owner == 2) m_resp <= 0;

      if (m_abort) begin
        m_state <= 0; m_cnt <= 0; m_elapsed <= 0;
      end else if (m_state == 0) m_state <= 1;
      else if (m_state == 1) m_state <= 2;
      else if (m_state == 2) begin
        if (tx_done && m_owner == 3) begin
          m_state <= 3; m_elapsed <= 0; m_cnt <= (m_cnt < 3) ? m_cnt + 1 : 3;
        end
      end else if (m_state == 3) begin
        // The response window is VT cycles long, counted from WAIT entry.
        if (rcv_r) m_state <= 4;
        else if (m_elapsed == VT - 1) m_state <= (m_cnt < VL) ? 1 : 5;
        else m_elapsed <= m_elapsed + 1;
      end
    end
  end

  function automatic int own_vec(input int o);
    case (o)
      1: return 8;
      2: return 4;
      3: return 2;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every output against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_state", int'(verify_state), m_state);
      chk("m_grants", int'({grant_e, grant_r, grant_v, grant_p}), own_vec(m_owner));
      chk("m_verified", int'(verified), int'(m_state == 4));
      chk("m_verify_fail", int'(verify_fail), int'(m_state == 5));
      chk("m_cnt", int'(verify_cnt), m_cnt);
      chk("m_preempt_en", int'(preempt_en), int'(m_pe));
      if (grant_p) gp_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_tx();
    tx_done = 1; tick(); tx_done = 0;
  endtask

  function automatic int sig_val(input int which);
    case (which)
      0: return int'(verify_state);
      1: return int'(grant_e);
      2: return int'(grant_r);
      3: return int'(grant_v);
      4: return int'(grant_p);
      default: return int'(verify_fail);
    endcase
  endfunction

  task automatic wait_sig(input string nm, input int which, input int val, input int budget);
    int n = 0;
    while (sig_val(which) != val && n < budget) begin
      tick();
      n++;
    end
    chk(nm, sig_val(which), val);
  endtask

  task automatic restart();
    p_enable = 0; tick(); p_enable = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 reset_n = 0;
    tick(); tick();
    chk_en = 1;
    chk("rst_state", int'(verify_state), 0);
    chk("rst_grants", int'({grant_e, grant_r, grant_v, grant_p}), 0);
    chk("rst_cnt", int'(verify_cnt), 0);
    chk("rst_verified", int'(verified), 0);

    // T1: basic verify success
    reset_n = 1; p_enable = 1;
    tick(); chk("t1_idle", int'(verify_state), 1);
    tick(); chk("t1_send", int'(verify_state), 2);
    tick(); chk("t1_gv", int'(grant_v), 1);
    tick(); pulse_tx();
    chk("t1_wait", int'(verify_state), 3);
    chk("t1_gv_off", int'(grant_v), 0);
    repeat (4) tick();
    rcv_r = 1; tick(); rcv_r = 0;
    chk("t1_verified_st", int'(verify_state), 4);
    chk("t1_verified", int'(verified), 1);
    chk("t1_cnt", int'(verify_cnt), 1);
    chk("t1_pe", int'(preempt_en), 1);

    // T2: no response -> three attempts then FAIL
    p_enable = 0; tick();
    chk("t2_init", int'(verify_state), 0);
    chk("t2_cnt0", int'(verify_cnt), 0);
    p_enable = 1; pmac_req = 1; gp_seen = 0;
    for (int a = 1; a <= 3; a++) begin
      wait_sig("t2_gv", 3, 1, 20);
      pulse_tx();
      n = 0;
      while (verify_state == 3'd3 && n < 20) begin n++; tick(); end
      chk("t2_wait_len", n, 8);
      chk("t2_cnt", int'(verify_cnt), a);
    end
    chk("t2_fail_st", int'(verify_state), 5);
    chk("t2_verify_fail", int'(verify_fail), 1);
    chk("t2_gp_never", gp_seen, 0);
    pmac_req = 0;

    // T3: arbitration order with VERIFIED
    restart();
    wait_sig("t3_gv", 3, 1, 20);
    pulse_tx(); tick();
    rcv_r = 1; tick(); rcv_r = 0;
    chk("t3_verified", int'(verify_state), 4);
    express_req = 1; pmac_req = 1; rcv_v = 1;
    tick(); rcv_v = 0; express_req = 0;
    chk("t3_e", int'({grant_e, grant_r, grant_v, grant_p}), 8);
    pulse_tx(); chk("t3_gap1", int'({grant_e, grant_r, grant_v, grant_p}), 0);
    tick(); chk("t3_r", int'({grant_e, grant_r, grant_v, grant_p}), 4);
    pulse_tx(); chk("t3_gap2", int'({grant_e, grant_r, grant_v, grant_p}), 0);
    tick(); chk("t3_p", int'({grant_e, grant_r, grant_v, grant_p}), 1);
    pulse_tx(); pmac_req = 0;
    chk("t3_gap3", int'({grant_e, grant_r, grant_v, grant_p}), 0);

    // T4: rcv_r coincides with timer expiry
    restart();
    wait_sig("t4_gv", 3, 1, 20);
    pulse_tx();
    repeat (7) tick();
    rcv_r = 1; tick(); rcv_r = 0;
    chk("t4_verified", int'(verify_state), 4);

    // T5: link_fail during grant_v on the second attempt
    restart();
    wait_sig("t5_gv1", 3, 1, 20);
    pulse_tx();
    wait_sig("t5_idle", 0, 1, 20);
    wait_sig("t5_gv2", 3, 1, 20);
    chk("t5_cnt1", int'(verify_cnt), 1);
    link_fail = 1; tick();
    chk("t5_gv_drop", int'(grant_v), 0);
    chk("t5_init", int'(verify_state), 0);
    chk("t5_cnt0", int'(verify_cnt), 0);
    link_fail = 0;
    wait_sig("t5_resend", 0, 2, 10);
    wait_sig("t5_gv3", 3, 1, 10);
    pulse_tx();

    // T6: disable_verify keeps an in-flight verify grant, then bypasses
    restart();
    wait_sig("t6_gv", 3, 1, 20);
    disable_verify = 1; tick();
    chk("t6_gv_held", int'(grant_v), 1);
    chk("t6_init", int'(verify_state), 0);
    pulse_tx();
    chk("t6_gv_rel", int'(grant_v), 0);
    chk("t6_no_adv", int'(verify_state), 0);
    repeat (3) tick();
    chk("t6_held_init", int'(verify_state), 0);
    chk("t6_pe", int'(preempt_en), 1);
    pmac_req = 1; tick();
    chk("t6_gp", int'(grant_p), 1);
    pulse_tx(); pmac_req = 0;
    rcv_v = 1; tick(); rcv_v = 0;
    tick(); chk("t6_gr", int'(grant_r), 1);
    pulse_tx();
    disable_verify = 0;

    // Randomized phase against the model
    reset_n = 0; tick(); reset_n = 1;
    for (int i = 0; i < 3000; i++) begin
      p_enable       = ($urandom_range(0, 49) != 0);
      link_fail      = ($urandom_range(0, 99) == 0);
      disable_verify = (i >= 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 199) == 0);
      express_req    = ($urandom_range(0, 7) == 0);
      pmac_req       = ($urandom_range(0, 1) == 1);
      tx_done        = ($urandom_range(0, 3) == 0);
      rcv_v          = ($urandom_range(0, 15) == 0);
      rcv_r          = ($urandom_range(0, 11) == 0);
      tick();
    end
    link_fail = 0; p_enable = 0; disable_verify = 0; express_req = 0;
    pmac_req = 0; tx_done = 0; rcv_v = 0; rcv_r = 0;
    tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
